// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/write-back
// on a shared datapath, stalling on a req/ready memory handshake.
module multi_cycle_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRd,
    output logic       MemWr,
    output logic       IorD,
    output logic       IRWr,
    output logic       PCWr,
    output logic       RegWr,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       Extop,
    output logic [3:0] ALUctr,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_R     = 4'd7,
        WB_I     = 4'd8,
        WB_MEM   = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_JR  = 6'b001000;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LUI = 4'd8;

    typedef struct packed {
        logic       mem_req;
        logic       mem_rd;
        logic       mem_wr;
        logic       i_or_d;
        logic       ir_wr;
        logic       pc_wr;
        logic       reg_wr;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_op;
        logic [3:0] alu_ctr;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       instr_done;
    } ctrl_t;

    state_t cur_state;
    state_t next_state;
    logic   illegal_q;
    ctrl_t  ctl;
    ctrl_t  ctl_out;

    logic       r_valid;
    logic       r_shift;
    logic [3:0] r_alu;
    logic       i_valid;
    logic [3:0] i_alu;

    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        r_valid = 1'b1;
        r_shift = 1'b0;
        r_alu   = ALU_ADD;
        case (func)
            F_ADD:   r_alu = ALU_ADD;
            F_SUB:   r_alu = ALU_SUB;
            F_AND:   r_alu = ALU_AND;
            F_OR:    r_alu = ALU_OR;
            F_XOR:   r_alu = ALU_XOR;
            F_SLL:   begin r_alu = ALU_SLL; r_shift = 1'b1; end
            F_SRL:   begin r_alu = ALU_SRL; r_shift = 1'b1; end
            F_SRA:   begin r_alu = ALU_SRA; r_shift = 1'b1; end
            default: r_valid = 1'b0;
        endcase
    end

    always_comb begin
        i_valid = 1'b1;
        i_alu   = ALU_ADD;
        case (op)
            OP_ADDI: i_alu = ALU_ADD;
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_XORI: i_alu = ALU_XOR;
            OP_LUI:  i_alu = ALU_LUI;
            default: i_valid = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (next_state == TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        ctl        = '0;
        next_state = cur_state;
        case (cur_state)
            FETCH: begin
                ctl.mem_req = 1'b1;
                ctl.mem_rd  = 1'b1;
                if (mem_ready) begin
                    ctl.ir_wr  = 1'b1;
                    ctl.pc_wr  = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                if (op == OP_RTYPE) begin
                    if (func == F_JR)  next_state = JUMP;
                    else if (r_valid)  next_state = EXEC_R;
                    else               next_state = TRAP;
                end else if (i_valid)                  next_state = EXEC_I;
                else if (op == OP_LW || op == OP_SW)   next_state = MEM_ADDR;
                else if (op == OP_BEQ)                 next_state = BRANCH;
                else if (op == OP_J || op == OP_JAL)   next_state = JUMP;
                else                                   next_state = TRAP;
            end
            EXEC_R: begin
                ctl.alu_ctr   = r_alu;
                ctl.alu_src_a = r_shift;
                next_state    = WB_R;
            end
            WB_R: begin
                // ALU selects stay as in EXEC_R so the result is stable while written back
                ctl.alu_ctr    = r_alu;
                ctl.alu_src_a  = r_shift;
                ctl.reg_wr     = 1'b1;
                ctl.reg_dst    = 2'b01;
                ctl.instr_done = 1'b1;
                next_state     = FETCH;
            end
            EXEC_I: begin
                ctl.alu_src_b = 1'b1;
                ctl.ext_op    = (op == OP_ADDI);
                ctl.alu_ctr   = i_alu;
                next_state    = WB_I;
            end
            WB_I: begin
                ctl.reg_wr     = 1'b1;
                ctl.instr_done = 1'b1;
                next_state     = FETCH;
            end
            MEM_ADDR: begin
                ctl.alu_src_b = 1'b1;
                ctl.ext_op    = 1'b1;
                ctl.alu_ctr   = ALU_ADD;
                next_state    = (op == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                ctl.mem_req = 1'b1;
                ctl.mem_rd  = 1'b1;
                ctl.i_or_d  = 1'b1;
                if (mem_ready) next_state = WB_MEM;
            end
            WB_MEM: begin
                ctl.reg_wr     = 1'b1;
                ctl.mem_to_reg = 2'b01;
                ctl.instr_done = 1'b1;
                next_state     = FETCH;
            end
            MEM_WR: begin
                ctl.mem_req = 1'b1;
                ctl.mem_wr  = 1'b1;
                ctl.i_or_d  = 1'b1;
                if (mem_ready) begin
                    ctl.instr_done = 1'b1;
                    next_state     = FETCH;
                end
            end
            BRANCH: begin
                ctl.alu_ctr    = ALU_SUB;
                ctl.ext_op     = 1'b1;
                ctl.pc_wr      = zero;
                ctl.pc_src     = 2'b01;
                ctl.instr_done = 1'b1;
                next_state     = FETCH;
            end
            JUMP: begin
                ctl.pc_wr      = 1'b1;
                ctl.instr_done = 1'b1;
                ctl.pc_src     = (op == OP_RTYPE) ? 2'b11 : 2'b10;
                if (op == OP_JAL) begin
                    ctl.reg_wr     = 1'b1;
                    ctl.reg_dst    = 2'b10;
                    ctl.mem_to_reg = 2'b10;
                end
                next_state = FETCH;
            end
            TRAP:    next_state = TRAP;
            default: next_state = FETCH;
        endcase
    end

    // Reset forces every output low in the same cycle, abandoning any pending access
    assign ctl_out    = rst ? '0 : ctl;
    assign mem_req    = ctl_out.mem_req;
    assign MemRd      = ctl_out.mem_rd;
    assign MemWr      = ctl_out.mem_wr;
    assign IorD       = ctl_out.i_or_d;
    assign IRWr       = ctl_out.ir_wr;
    assign PCWr       = ctl_out.pc_wr;
    assign RegWr      = ctl_out.reg_wr;
    assign PCSrc      = ctl_out.pc_src;
    assign ALUSrcA    = ctl_out.alu_src_a;
    assign ALUSrcB    = ctl_out.alu_src_b;
    assign Extop      = ctl_out.ext_op;
    assign ALUctr     = ctl_out.alu_ctr;
    assign RegDst     = ctl_out.reg_dst;
    assign MemtoReg   = ctl_out.mem_to_reg;
    assign instr_done = ctl_out.instr_done;
    assign illegal    = illegal_q & ~rst;
    assign state      = rst ? 4'd0 : cur_state;

endmodule
